controlador_entrada_saida: RTL and testbench

Sequencing controller for the processor's I/O unit. On an input instruction it stalls the processor, waits for a debounced press-and-release of the confirm key, then hands over the captured switch value with a one-cycle completion pulse. On an output instruction it latches the processor value into a held display register and raises the valid flag that gates the BCD/7-segment output path.

---
 rtl/controlador_entrada_saida_if.sv | 27 ++
 rtl/controlador_entrada_saida.sv | 93 +++++++++
 tb/tb_controlador_entrada_saida.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/controlador_entrada_saida_if.sv
// controlador_entrada_saida_if: processor/board handshake bundle for the I/O sequencing controller.
interface controlador_entrada_saida_if #(
   parameter int LARGURA        = 32,
   parameter int LARGURA_CHAVES = 18
);
   logic                      req_entrada;
   logic                      req_saida;
   logic [LARGURA-1:0]        dado_saida;
   logic [LARGURA_CHAVES-1:0] chaves;
   logic                      botao;
   logic                      pausa;
   logic                      pronto;
   logic [LARGURA-1:0]        dado_entrada;
   logic [LARGURA-1:0]        reg_saida;
   logic                      saida_valida;
   logic                      aguardando;

   modport master (
      output req_entrada, req_saida, dado_saida, chaves, botao,
      input  pausa, pronto, dado_entrada, reg_saida, saida_valida, aguardando
   );

   modport slave (
      input  req_entrada, req_saida, dado_saida, chaves, botao,
      output pausa, pronto, dado_entrada, reg_saida, saida_valida, aguardando
   );
endinterface

// File: rtl/controlador_entrada_saida.sv
// controlador_entrada_saida: stalls input instructions until a debounced key press/release, holds output writes.
module controlador_entrada_saida #(
   parameter int LARGURA         = 32,
   parameter int LARGURA_CHAVES  = 18,
   parameter int DEBOUNCE_CICLOS = 50000,
   parameter int LARGURA_CONT    = 16
) (
   input logic                   clock,
   input logic                   reset,
   controlador_entrada_saida_if.slave bus
);
   typedef enum logic [1:0] {OCIOSO, ESPERA_PRESS, ESPERA_SOLTA, CONCLUI} estado_t;

   localparam logic [LARGURA_CONT-1:0] FIM = LARGURA_CONT'(DEBOUNCE_CICLOS - 1);

   estado_t                   estado_q, estado_d;
   logic [LARGURA_CONT-1:0]   cont_q, cont_d;
   logic                      botao_m_q, botao_s_q;
   logic [LARGURA_CHAVES-1:0] chaves_m_q, chaves_s_q;
   logic [LARGURA-1:0]        dado_q, dado_d;
   logic [LARGURA-1:0]        reg_q, reg_d;
   logic                      valida_q, valida_d;
   logic                      aguardando, escrita, fim_cont;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado_q   <= OCIOSO;
         cont_q     <= '0;
         botao_m_q  <= 1'b0;
         botao_s_q  <= 1'b0;
         chaves_m_q <= '0;
         chaves_s_q <= '0;
         dado_q     <= '0;
         reg_q      <= '0;
         valida_q   <= 1'b0;
      end else begin
         estado_q   <= estado_d;
         cont_q     <= cont_d;
         botao_m_q  <= bus.botao;
         botao_s_q  <= botao_m_q;
         chaves_m_q <= bus.chaves;
         chaves_s_q <= chaves_m_q;
         dado_q     <= dado_d;
         reg_q      <= reg_d;
         valida_q   <= valida_d;
      end
   end

   assign fim_cont = cont_q == FIM;

   always_comb begin
      estado_d = estado_q;
      cont_d   = cont_q;
      dado_d   = dado_q;
      case (estado_q)
         OCIOSO: begin
            if (bus.req_entrada) begin
               estado_d = ESPERA_PRESS;
               cont_d   = '0;
            end
         end
         ESPERA_PRESS: begin
            cont_d = botao_s_q ? cont_q + LARGURA_CONT'(1) : '0;
            if (botao_s_q && fim_cont) begin
               dado_d   = LARGURA'(chaves_s_q);
               cont_d   = '0;
               estado_d = ESPERA_SOLTA;
            end
         end
         ESPERA_SOLTA: begin
            cont_d = !botao_s_q ? cont_q + LARGURA_CONT'(1) : '0;
            if (!botao_s_q && fim_cont) begin
               cont_d   = '0;
               estado_d = CONCLUI;
            end
         end
         default: estado_d = OCIOSO;
      endcase
   end

   // The stall must be visible in the request cycle itself, so it is decoded combinationally.
   assign aguardando = estado_q == ESPERA_PRESS || estado_q == ESPERA_SOLTA;
   assign bus.pausa  = !reset && (estado_q == OCIOSO ? bus.req_entrada : aguardando);
   assign escrita    = bus.req_saida && !bus.pausa;
   assign reg_d      = escrita ? bus.dado_saida : reg_q;
   assign valida_d   = valida_q || escrita;

   assign bus.pronto       = estado_q == CONCLUI;
   assign bus.aguardando   = aguardando;
   assign bus.dado_entrada = dado_q;
   assign bus.reg_saida    = reg_q;
   assign bus.saida_valida = valida_q;
endmodule

// File: tb/tb_controlador_entrada_saida.sv
// tb_controlador_entrada_saida: vector table, directed corner sequences and random stimulus against a reference model.
module tb_controlador_entrada_saida;
   localparam int D = 4;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   controlador_entrada_saida_if #(.LARGURA(32), .LARGURA_CHAVES(18)) bus ();

   controlador_entrada_saida #(
      .LARGURA(32), .LARGURA_CHAVES(18), .DEBOUNCE_CICLOS(D), .LARGURA_CONT(3)
   ) dut (
      .clock(clock),
      .reset(reset),
      .bus(bus)
   );

   int total = 0, passed = 0;

   int          fase;
   logic        bm, bs;
   logic [17:0] cm, cs;
   bit          hist[$];
   logic [31:0] m_dado, m_reg;
   logic        m_val;

   typedef struct {
      logic re, rs; logic [31:0] ds; logic [17:0] ch; logic b;
      logic p, r, a; logic [31:0] de, rg; logic v;
   } vec_t;
   vec_t tab[19];

   task automatic chk(input string nome, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h at %0t", nome, act, exp, $time);
   endtask

   function automatic bit ultimos(input bit v);
      if (hist.size() < D) return 1'b0;
      foreach (hist[i]) if (hist[i] != v) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic m_pausa();
      return fase == 0 ? bus.req_entrada : (fase == 1 || fase == 2);
   endfunction

   task automatic model_reset();
      fase = 0; bm = 0; bs = 0; cm = '0; cs = '0;
      hist.delete(); m_dado = '0; m_reg = '0; m_val = 0;
   endtask

   task automatic model_compare();
      chk("pausa", {31'b0, bus.pausa}, {31'b0, m_pausa()});
      chk("pronto", {31'b0, bus.pronto}, fase == 3);
      chk("aguardando", {31'b0, bus.aguardando}, fase == 1 || fase == 2);
      chk("dado_entrada", bus.dado_entrada, m_dado);
      chk("reg_saida", bus.reg_saida, m_reg);
      chk("saida_valida", {31'b0, bus.saida_valida}, {31'b0, m_val});
   endtask

   task automatic model_update();
      if (bus.req_saida && !m_pausa()) begin m_reg = bus.dado_saida; m_val = 1; end
      case (fase)
         0: if (bus.req_entrada) begin fase = 1; hist.delete(); end
         1: begin
            hist.push_back(bs);
            if (hist.size() > D) void'(hist.pop_front());
            if (ultimos(1'b1)) begin m_dado = {14'b0, cs}; fase = 2; hist.delete(); end
         end
         2: begin
            hist.push_back(bs);
            if (hist.size() > D) void'(hist.pop_front());
            if (ultimos(1'b0)) begin fase = 3; hist.delete(); end
         end
         default: fase = 0;
      endcase
      bs = bm; bm = bus.botao; cs = cm; cm = bus.chaves;
   endtask

   task automatic half();
      @(negedge clock);
      model_compare();
   endtask

   task automatic rest();
      int f;
      f = fase;
      model_update();
      @(posedge clock);
      #1;
      if (f == 3) bus.req_entrada = 1'b0;
   endtask

   task automatic cycle();
      half();
      rest();
   endtask

   task automatic hold(input logic b, input int n);
      bus.botao = b;
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic aleatoriza();
      bus.req_entrada = 1'($urandom_range(0, 1));
      bus.req_saida   = 1'($urandom_range(0, 1));
      bus.dado_saida  = $urandom;
      bus.chaves      = 18'($urandom);
      bus.botao       = 1'($urandom_range(0, 1));
   endtask

   task automatic chk_zero(input string nome);
      chk({nome, "_pausa"}, {31'b0, bus.pausa}, 32'd0);
      chk({nome, "_pronto"}, {31'b0, bus.pronto}, 32'd0);
      chk({nome, "_aguardando"}, {31'b0, bus.aguardando}, 32'd0);
      chk({nome, "_dado_entrada"}, bus.dado_entrada, 32'd0);
      chk({nome, "_reg_saida"}, bus.reg_saida, 32'd0);
      chk({nome, "_saida_valida"}, {31'b0, bus.saida_valida}, 32'd0);
   endtask

   task automatic do_reset(input int n);
      aleatoriza();
      bus.req_entrada = 1'b1;
      reset = 1'b1;
      #1;
      chk_zero("reset_imediato");
      for (int i = 0; i < n; i++) begin
         aleatoriza();
         @(negedge clock);
         chk_zero("reset_ativo");
         @(posedge clock);
         #1;
      end
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      int run_left;
      logic b;
      reset = 1'b1;
      bus.req_entrada = 0; bus.req_saida = 0; bus.dado_saida = '0; bus.chaves = '0; bus.botao = 0;
      model_reset();
      @(posedge clock);
      #1;
      do_reset(3);

      for (int i = 0; i < 19; i++) begin
         tab[i].re = i <= 15;  tab[i].rs = i == 17;
         tab[i].ds = i == 17 ? 32'd1234 : 32'd0;
         tab[i].ch = 18'h0002A; tab[i].b = i >= 1 && i <= 8;
         tab[i].p  = i <= 14;  tab[i].r = i == 15;  tab[i].a = i >= 1 && i <= 14;
         tab[i].de = i >= 7 ? 32'h2A : 32'd0;
         tab[i].rg = i >= 18 ? 32'd1234 : 32'd0;
         tab[i].v  = i >= 18;
      end
      for (int i = 0; i < 19; i++) begin
         bus.req_entrada = tab[i].re; bus.req_saida = tab[i].rs; bus.dado_saida = tab[i].ds;
         bus.chaves = tab[i].ch; bus.botao = tab[i].b;
         half();
         chk($sformatf("tab%0d_pausa", i), {31'b0, bus.pausa}, {31'b0, tab[i].p});
         chk($sformatf("tab%0d_pronto", i), {31'b0, bus.pronto}, {31'b0, tab[i].r});
         chk($sformatf("tab%0d_aguardando", i), {31'b0, bus.aguardando}, {31'b0, tab[i].a});
         chk($sformatf("tab%0d_dado_entrada", i), bus.dado_entrada, tab[i].de);
         chk($sformatf("tab%0d_reg_saida", i), bus.reg_saida, tab[i].rg);
         chk($sformatf("tab%0d_saida_valida", i), {31'b0, bus.saida_valida}, {31'b0, tab[i].v});
         rest();
      end
      bus.req_saida = 0;

      bus.chaves = 18'h3FFFF; bus.req_entrada = 1;
      hold(0, 1); hold(1, 7); hold(0, 8);
      chk("hold_reg_saida", bus.reg_saida, 32'd1234);
      chk("hold_saida_valida", {31'b0, bus.saida_valida}, 32'd1);
      chk("hold_dado_entrada", bus.dado_entrada, 32'h3FFFF);

      bus.chaves = 18'h15555; bus.req_entrada = 1;
      hold(0, 1); hold(1, 1); hold(0, 2); hold(1, 2); hold(0, 2); hold(1, 3); hold(0, 2);
      chk("bounce_aguardando", {31'b0, bus.aguardando}, 32'd1);
      chk("bounce_dado_entrada", bus.dado_entrada, 32'h3FFFF);
      hold(1, 4); hold(0, 8);
      chk("bounce_captura", bus.dado_entrada, 32'h15555);

      bus.req_entrada = 1; bus.req_saida = 1; bus.dado_saida = 32'd99;
      cycle();
      bus.req_saida = 0;
      chk("simult_reg_saida", bus.reg_saida, 32'd1234);
      chk("simult_aguardando", {31'b0, bus.aguardando}, 32'd1);
      hold(1, 7); hold(0, 8);

      bus.chaves = 18'h00100; bus.req_entrada = 1;
      hold(0, 1); hold(1, 7); hold(0, 2);
      chk("solta_dado_entrada", bus.dado_entrada, 32'h100);
      chk("solta_aguardando", {31'b0, bus.aguardando}, 32'd1);
      do_reset(2);
      bus.req_entrada = 1; bus.req_saida = 0; bus.chaves = 18'h00100;
      hold(0, 6);
      chk("pos_reset_aguardando", {31'b0, bus.aguardando}, 32'd1);
      chk("pos_reset_dado_entrada", bus.dado_entrada, 32'd0);
      hold(1, 7); hold(0, 8);
      chk("pos_reset_captura", bus.dado_entrada, 32'h100);

      run_left = 0; b = 0;
      for (int k = 0; k < 800; k++) begin
         if (run_left == 0) begin b = ~b; run_left = $urandom_range(1, 7); end
         run_left--;
         bus.botao = b;
         bus.req_saida = $urandom_range(0, 3) == 0;
         bus.dado_saida = $urandom;
         if ($urandom_range(0, 7) == 0) bus.chaves = 18'($urandom);
         if (fase == 0) bus.req_entrada = 1'($urandom_range(0, 1));
         else if (fase != 3) bus.req_entrada = 1'b1;
         if (k == 400) do_reset(2);
         else cycle();
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
